// File: rtl/tm_qm_ll.sv
`timescale 1ns/1ps
// Linked-list queue manager: NUM_QUEUES queues share one entry pool, and the
// free list is threaded through the same next-pointer memory and built during INIT.
module tm_qm_ll #(
  parameter int QUEUE_ID_NBITS      = 4,
  parameter int QUEUE_ENTRIES_NBITS = 6,
  parameter int DESC_NBITS          = 32,
  parameter int QUEUE_DEPTH_MAX     = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         enq_req,
  input  logic [QUEUE_ID_NBITS-1:0]    enq_qid,
  input  logic [DESC_NBITS-1:0]        enq_desc,
  output logic                         enq_ack,
  output logic                         enq_drop,
  input  logic                         deq_req,
  input  logic [QUEUE_ID_NBITS-1:0]    deq_qid,
  output logic                         deq_ack,
  output logic                         deq_empty,
  output logic [DESC_NBITS-1:0]        deq_desc,
  output logic                         init_done,
  output logic [QUEUE_ENTRIES_NBITS:0] free_count
);

  localparam int QW         = QUEUE_ID_NBITS;
  localparam int EW         = QUEUE_ENTRIES_NBITS;
  localparam int CW         = EW + 1;
  localparam int NUM_QUEUES = 2 ** QW;
  localparam int ENTRIES    = 2 ** EW;
  localparam int INIT_N     = (NUM_QUEUES > ENTRIES) ? NUM_QUEUES : ENTRIES;
  localparam int IW         = ((QW > EW) ? QW : EW) + 1;

  localparam logic [IW-1:0] INIT_LAST   = IW'(INIT_N - 1);
  localparam logic [IW-1:0] ENTRIES_I   = IW'(ENTRIES);
  localparam logic [IW-1:0] NUMQ_I      = IW'(NUM_QUEUES);
  localparam logic [CW-1:0] DEPTH_MAX_C = CW'(QUEUE_DEPTH_MAX);
  localparam logic [CW-1:0] ENTRIES_C   = CW'(ENTRIES);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ENQ_RD, S_ENQ_WR, S_DEQ_RD, S_DEQ_RD2, S_DEQ_WR
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]         init_cnt;
  logic [EW-1:0]         free_head, free_tail;
  logic                  last_grant_deq;
  logic [QW-1:0]         cur_qid;

  logic [EW-1:0]         head_mem  [NUM_QUEUES];
  logic [EW-1:0]         tail_mem  [NUM_QUEUES];
  logic [CW-1:0]         depth_mem [NUM_QUEUES];
  logic [EW-1:0]         ll_mem    [ENTRIES];
  logic [DESC_NBITS-1:0] desc_mem  [ENTRIES];

  logic [EW-1:0]         head_rd, tail_rd, ll_rd;
  logic [CW-1:0]         depth_rd;
  logic [DESC_NBITS-1:0] desc_rd;

  logic                  enq_elig, deq_elig, grant_enq, grant_deq, drop;
  logic                  q_re, ent_re;
  logic [EW-1:0]         ent_raddr;
  logic                  head_we, tail_we, depth_we, ll_we, desc_we;
  logic [EW-1:0]         head_wdata, ll_waddr, ll_wdata;
  logic [QW-1:0]         depth_waddr;
  logic [CW-1:0]         depth_wdata;

  // A port whose ack is showing this cycle is still holding req from the old request.
  assign enq_elig = enq_req && !enq_ack;
  assign deq_elig = deq_req && !deq_ack;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_enq   = 1'b0;
    grant_deq   = 1'b0;
    q_re        = 1'b0;
    ent_re      = 1'b0;
    ent_raddr   = free_head;
    head_we     = 1'b0;
    head_wdata  = free_head;
    tail_we     = 1'b0;
    depth_we    = 1'b0;
    depth_waddr = cur_qid;
    depth_wdata = '0;
    ll_we       = 1'b0;
    ll_waddr    = init_cnt[EW-1:0];
    ll_wdata    = init_cnt[EW-1:0] + EW'(1);
    desc_we     = 1'b0;
    drop        = (depth_rd >= DEPTH_MAX_C) || (free_count == '0);
    case (state)
      S_INIT: begin
        ll_we       = (init_cnt < ENTRIES_I);
        depth_we    = (init_cnt < NUMQ_I);
        depth_waddr = init_cnt[QW-1:0];
        if (init_cnt == INIT_LAST) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (enq_elig && deq_elig) begin
          grant_enq = last_grant_deq;
          grant_deq = !last_grant_deq;
        end else begin
          grant_enq = enq_elig;
          grant_deq = deq_elig;
        end
        if (grant_enq)      state_nxt = S_ENQ_RD;
        else if (grant_deq) state_nxt = S_DEQ_RD;
      end
      S_ENQ_RD: begin
        q_re      = 1'b1;
        ent_re    = 1'b1;
        state_nxt = S_ENQ_WR;
      end
      S_ENQ_WR: begin
        if (!drop) begin
          desc_we     = 1'b1;
          head_we     = (depth_rd == '0);
          ll_we       = (depth_rd != '0);
          ll_waddr    = tail_rd;
          ll_wdata    = free_head;
          tail_we     = 1'b1;
          depth_we    = 1'b1;
          depth_wdata = depth_rd + CW'(1);
        end
        state_nxt = S_IDLE;
      end
      S_DEQ_RD: begin
        q_re      = 1'b1;
        state_nxt = S_DEQ_RD2;
      end
      S_DEQ_RD2: begin
        if (depth_rd == '0) begin
          state_nxt = S_IDLE;
        end else begin
          ent_re    = 1'b1;
          ent_raddr = head_rd;
          state_nxt = S_DEQ_WR;
        end
      end
      S_DEQ_WR: begin
        depth_we    = 1'b1;
        depth_wdata = depth_rd - CW'(1);
        head_we     = (depth_rd > CW'(1));
        head_wdata  = ll_rd;
        ll_we       = (free_count != '0);
        ll_waddr    = free_tail;
        ll_wdata    = head_rd;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_cnt       <= '0;
      init_done      <= 1'b0;
      free_head      <= '0;
      free_tail      <= EW'(ENTRIES - 1);
      free_count     <= '0;
      last_grant_deq <= 1'b1;
      cur_qid        <= '0;
      enq_ack        <= 1'b0;
      enq_drop       <= 1'b0;
      deq_ack        <= 1'b0;
      deq_empty      <= 1'b0;
      deq_desc       <= '0;
    end else begin
      enq_ack <= 1'b0;
      deq_ack <= 1'b0;
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + IW'(1);
          if (init_cnt == INIT_LAST) begin
            init_done  <= 1'b1;
            free_count <= ENTRIES_C;
          end
        end
        S_IDLE: begin
          if (grant_enq) begin
            cur_qid        <= enq_qid;
            last_grant_deq <= 1'b0;
          end else if (grant_deq) begin
            cur_qid        <= deq_qid;
            last_grant_deq <= 1'b1;
          end
        end
        S_ENQ_WR: begin
          enq_ack  <= 1'b1;
          enq_drop <= drop;
          if (!drop) begin
            free_head  <= ll_rd;
            free_count <= free_count - CW'(1);
          end
        end
        S_DEQ_RD2: begin
          if (depth_rd == '0) begin
            deq_ack   <= 1'b1;
            deq_empty <= 1'b1;
          end
        end
        S_DEQ_WR: begin
          deq_ack   <= 1'b1;
          deq_empty <= 1'b0;
          deq_desc  <= desc_rd;
          // An empty free list has no tail link to extend; the entry becomes the whole list.
          if (free_count == '0) free_head <= head_rd;
          free_tail  <= head_rd;
          free_count <= free_count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (head_we)  head_mem[cur_qid]      <= head_wdata;
    if (tail_we)  tail_mem[cur_qid]      <= free_head;
    if (depth_we) depth_mem[depth_waddr] <= depth_wdata;
    if (ll_we)    ll_mem[ll_waddr]       <= ll_wdata;
    if (desc_we)  desc_mem[free_head]    <= enq_desc;
    if (q_re) begin
      head_rd  <= head_mem[cur_qid];
      tail_rd  <= tail_mem[cur_qid];
      depth_rd <= depth_mem[cur_qid];
    end
    if (ent_re) begin
      ll_rd   <= ll_mem[ent_raddr];
      desc_rd <= desc_mem[ent_raddr];
    end
  end

endmodule

// File: tb/tb_tm_qm_ll.sv
`timescale 1ns/1ps
// Bench for tm_qm_ll: a per-queue FIFO model pushes expected acks to a
// scoreboard queue; each test pops them as the DUT answers.
module tb_tm_qm_ll;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enq_req = 1'b0;
  logic [3:0]  enq_qid = '0;
  logic [31:0] enq_desc = '0;
  logic        enq_ack, enq_drop;
  logic        deq_req = 1'b0;
  logic [3:0]  deq_qid = '0;
  logic        deq_ack, deq_empty;
  logic [31:0] deq_desc;
  logic        init_done;
  logic [6:0]  free_count;

  always #5 clk = ~clk;

  tm_qm_ll #(
    .QUEUE_ID_NBITS(4), .QUEUE_ENTRIES_NBITS(6), .DESC_NBITS(32), .QUEUE_DEPTH_MAX(32)
  ) dut (
    .clk(clk), .rstn(rstn),
    .enq_req(enq_req), .enq_qid(enq_qid), .enq_desc(enq_desc),
    .enq_ack(enq_ack), .enq_drop(enq_drop),
    .deq_req(deq_req), .deq_qid(deq_qid),
    .deq_ack(deq_ack), .deq_empty(deq_empty), .deq_desc(deq_desc),
    .init_done(init_done), .free_count(free_count)
  );

  typedef struct {
    bit          is_deq;
    bit          flag;
    logic [31:0] desc;
    int          lat;
    int          free;
  } exp_t;

  typedef struct {
    bit          is_deq;
    int          q;
    logic [31:0] d;
  } op_t;

  exp_t        sb[$];
  logic [31:0] mdata [16][64];
  int          mrd [16];
  int          mwr [16];
  int          mdepth [16];
  int          mfree;
  logic [31:0] mlast;
  int          checks = 0;
  int          passes = 0;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      mrd[i] = 0; mwr[i] = 0; mdepth[i] = 0;
    end
    mfree = 64;
    mlast = '0;
    sb.delete();
  endfunction

  function automatic void exp_enq(input int q, input logic [31:0] d);
    exp_t e;
    e.is_deq = 1'b0;
    e.flag   = (mdepth[q] >= 32) || (mfree == 0);
    e.desc   = d;
    e.lat    = 3;
    if (!e.flag) begin
      mdata[q][mwr[q]] = d;
      mwr[q] = (mwr[q] + 1) % 64;
      mdepth[q]++;
      mfree--;
    end
    e.free = mfree;
    sb.push_back(e);
  endfunction

  function automatic void exp_deq(input int q);
    exp_t e;
    e.is_deq = 1'b1;
    if (mdepth[q] == 0) begin
      e.flag = 1'b1;
      e.desc = mlast;
      e.lat  = 3;
    end else begin
      e.flag = 1'b0;
      e.desc = mdata[q][mrd[q]];
      mrd[q] = (mrd[q] + 1) % 64;
      mdepth[q]--;
      mfree++;
      mlast = e.desc;
      e.lat = 4;
    end
    e.free = mfree;
    sb.push_back(e);
  endfunction

  task automatic drive_enq(input logic [3:0] q, input logic [31:0] d,
                           output logic flag, output int lat, output int fc);
    @(posedge clk); #1;
    enq_qid = q; enq_desc = d; enq_req = 1'b1; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (enq_ack !== 1'b1 && lat < 40);
    flag = enq_drop; fc = int'(free_count); enq_req = 1'b0;
  endtask

  task automatic drive_deq(input logic [3:0] q, output logic flag, output logic [31:0] d,
                           output int lat, output int fc);
    @(posedge clk); #1;
    deq_qid = q; deq_req = 1'b1; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (deq_ack !== 1'b1 && lat < 40);
    flag = deq_empty; d = deq_desc; fc = int'(free_count); deq_req = 1'b0;
  endtask

  task automatic test_reset();
    int cyc, lat, fc;
    bit early;
    exp_t e;
    logic f;
    logic [31:0] d;
    rstn = 1'b0; enq_req = 1'b1; enq_qid = 4'd0; enq_desc = 32'h55; deq_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({enq_ack, enq_drop, deq_ack, deq_empty, init_done} !== 5'b0 || deq_desc !== 32'h0 ||
        free_count !== 7'd0)
      $display("[TB] FAIL reset_outputs: got acks=%b%b%b%b init=%b desc=%h free=%0d, want all 0",
               enq_ack, enq_drop, deq_ack, deq_empty, init_done, deq_desc, free_count);
    else passes++;
    #2 rstn = 1'b1;
    model_reset();
    exp_enq(0, 32'h55);
    cyc = 0; early = 1'b0;
    while (init_done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if ((enq_ack === 1'b1 || deq_ack === 1'b1) && init_done !== 1'b1) early = 1'b1;
    end
    checks++;
    if (cyc != 64) $display("[TB] FAIL init_cycles: got %0d, want 64", cyc);
    else passes++;
    checks++;
    if (early) $display("[TB] FAIL ack_before_init: got ack during init, want none");
    else passes++;
    checks++;
    if (free_count !== 7'd64) $display("[TB] FAIL init_free: got %0d, want 64", free_count);
    else passes++;
    lat = 0;
    while (enq_ack !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    fc = int'(free_count);
    checks++;
    if (enq_drop !== e.flag || lat != e.lat || fc != e.free)
      $display("[TB] FAIL held_enq: got drop=%b lat=%0d free=%0d, want drop=%b lat=%0d free=%0d",
               enq_drop, lat, fc, e.flag, e.lat, e.free);
    else passes++;
    enq_req = 1'b0;
    exp_deq(0);
    drive_deq(4'd0, f, d, lat, fc);
    e = sb.pop_front();
    checks++;
    if (f !== e.flag || d !== e.desc || lat != e.lat || fc != e.free)
      $display("[TB] FAIL drain_q0: got empty=%b desc=%h lat=%0d free=%0d, want %b %h %0d %0d",
               f, d, lat, fc, e.flag, e.desc, e.lat, e.free);
    else passes++;
  endtask

  task automatic run_table(input string name, input op_t ops[$]);
    exp_t e;
    logic f;
    logic [31:0] d;
    int lat, fc;
    foreach (ops[i]) begin
      if (!ops[i].is_deq) begin
        exp_enq(ops[i].q, ops[i].d);
        drive_enq(4'(ops[i].q), ops[i].d, f, lat, fc);
        e = sb.pop_front();
        checks++;
        if (f !== e.flag || lat != e.lat || fc != e.free)
          $display("[TB] FAIL %s_enq%0d: got drop=%b lat=%0d free=%0d, want drop=%b lat=%0d free=%0d",
                   name, i, f, lat, fc, e.flag, e.lat, e.free);
        else passes++;
      end else begin
        exp_deq(ops[i].q);
        drive_deq(4'(ops[i].q), f, d, lat, fc);
        e = sb.pop_front();
        checks++;
        if (f !== e.flag || d !== e.desc || lat != e.lat || fc != e.free)
          $display("[TB] FAIL %s_deq%0d: got empty=%b desc=%h lat=%0d free=%0d, want %b %h %0d %0d",
                   name, i, f, d, lat, fc, e.flag, e.desc, e.lat, e.free);
        else passes++;
      end
    end
  endtask

  task automatic test_fifo_order();
    op_t ops[$];
    for (int i = 0; i < 3; i++) ops.push_back('{1'b0, 3, 32'hA0 + i});
    for (int i = 0; i < 3; i++) ops.push_back('{1'b1, 3, 32'h0});
    run_table("fifo", ops);
    checks++;
    if (free_count !== 7'd64) $display("[TB] FAIL fifo_free: got %0d, want 64", free_count);
    else passes++;
  endtask

  task automatic test_deq_empty();
    op_t ops[$];
    ops.push_back('{1'b1, 5, 32'h0});
    run_table("empty", ops);
  endtask

  task automatic test_depth_limit();
    op_t ops[$];
    for (int i = 0; i < 33; i++) ops.push_back('{1'b0, 1, 32'h100 + i});
    run_table("depth", ops);
    checks++;
    if (free_count !== 7'd32) $display("[TB] FAIL depth_free: got %0d, want 32", free_count);
    else passes++;
  endtask

  task automatic test_free_exhaust();
    op_t ops[$];
    op_t tail_ops[$];
    for (int i = 0; i < 32; i++) ops.push_back('{1'b0, 0, 32'h200 + i});
    run_table("fill", ops);
    checks++;
    if (free_count !== 7'd0) $display("[TB] FAIL exhaust_free: got %0d, want 0", free_count);
    else passes++;
    tail_ops.push_back('{1'b0, 2, 32'h300});
    tail_ops.push_back('{1'b1, 0, 32'h0});
    tail_ops.push_back('{1'b0, 2, 32'h301});
    tail_ops.push_back('{1'b1, 2, 32'h0});
    run_table("exhaust", tail_ops);
  endtask

  task automatic test_back_to_back();
    int n_enq, n_deq, cyc;
    bit expect_deq;
    logic [31:0] nd;
    exp_t e;
    n_enq = 0; n_deq = 0; cyc = 0; expect_deq = 1'b0; nd = 32'h700;
    @(posedge clk); #1;
    enq_qid = 4'd7; deq_qid = 4'd7; enq_desc = nd; enq_req = 1'b1; deq_req = 1'b1;
    while (n_deq < 10 && cyc < 400) begin
      @(posedge clk); #1; cyc++;
      if (enq_ack === 1'b1) begin
        checks++;
        if (expect_deq) $display("[TB] FAIL b2b_order_enq%0d: got enq ack, want deq ack", n_enq);
        else passes++;
        exp_enq(7, nd);
        e = sb.pop_front();
        checks++;
        if (enq_drop !== e.flag || int'(free_count) != e.free)
          $display("[TB] FAIL b2b_enq%0d: got drop=%b free=%0d, want drop=%b free=%0d",
                   n_enq, enq_drop, free_count, e.flag, e.free);
        else passes++;
        expect_deq = 1'b1; n_enq++; nd = nd + 32'h1; enq_desc = nd;
      end
      if (deq_ack === 1'b1) begin
        checks++;
        if (!expect_deq) $display("[TB] FAIL b2b_order_deq%0d: got deq ack, want enq ack", n_deq);
        else passes++;
        exp_deq(7);
        e = sb.pop_front();
        checks++;
        if (deq_empty !== e.flag || deq_desc !== e.desc || int'(free_count) != e.free)
          $display("[TB] FAIL b2b_deq%0d: got empty=%b desc=%h free=%0d, want %b %h %0d",
                   n_deq, deq_empty, deq_desc, free_count, e.flag, e.desc, e.free);
        else passes++;
        expect_deq = 1'b0; n_deq++;
        if (n_deq == 10) begin
          enq_req = 1'b0; deq_req = 1'b0;
        end
      end
    end
    enq_req = 1'b0; deq_req = 1'b0;
    checks++;
    if (n_deq < 10) $display("[TB] FAIL b2b_timeout: got %0d deq acks, want 10", n_deq);
    else passes++;
  endtask

  task automatic test_reset_mid_op();
    op_t ops[$];
    op_t post[$];
    int cyc;
    ops.push_back('{1'b0, 3, 32'hB0});
    run_table("pre_rst", ops);
    @(posedge clk); #1;
    deq_qid = 4'd3; deq_req = 1'b1;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({enq_ack, enq_drop, deq_ack, deq_empty, init_done} !== 5'b0 || deq_desc !== 32'h0 ||
        free_count !== 7'd0)
      $display("[TB] FAIL midop_reset: got acks=%b%b%b%b init=%b desc=%h free=%0d, want all 0",
               enq_ack, enq_drop, deq_ack, deq_empty, init_done, deq_desc, free_count);
    else passes++;
    deq_req = 1'b0;
    @(posedge clk);
    #3 rstn = 1'b1;
    model_reset();
    cyc = 0;
    while (init_done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc != 64) $display("[TB] FAIL reinit_cycles: got %0d, want 64", cyc);
    else passes++;
    post.push_back('{1'b1, 3, 32'h0});
    run_table("post_rst", post);
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_deq_empty();
    test_depth_limit();
    test_free_exhaust();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
